// File: rtl/w5300_socket_n_tx.sv
// -----------------------------------------------------------------------------
// w5300_socket_n_tx
//   Socket-N transmit stage of the W5300 driver. While enable_i is high it
//   polls Sn_TX_FSR until the free space covers the payload, streams the
//   payload words from the user TX buffer into Sn_TX_FIFOR, writes the byte
//   count to Sn_TX_WRSR, issues SEND through Sn_CR and waits for Sn_CR to
//   clear. It then pulses done_o, or error_o if the free-space poll times out.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   enable_i    level, high while the driver entry is in Transmitting
//   tx_len_i    payload length in bytes, sampled on the enable_i rising edge
//   addr_o      {wr, reg_addr[9:0]} towards the interface (wr=1 write)
//   wr_data_o   write data towards the interface
//   rd_data_i   read data from the interface, valid with op_state_i
//   op_state_i  1-cycle pulse, interface finished the access on addr_o
//   buf_addr_o  user TX buffer word address
//   buf_data_i  buffer read data, valid one cycle after buf_addr_o
//   done_o      1-cycle pulse, SEND accepted (Sn_CR read back as zero)
//   error_o     1-cycle pulse, free-space poll timed out, FIFO untouched
//
// State table
//   IDLE      | waiting for enable rise, tx_len latched on the rise
//   RD_FSR_H  | reading Sn_TX_FSR upper half
//   RD_FSR_L  | reading Sn_TX_FSR lower half
//   CHECK     | free space vs payload, retry poll or give up
//   FETCH     | buffer word in flight, captured at end of cycle
//   WR_FIFO   | writing one payload word to Sn_TX_FIFOR
//   WR_WRSR_H | writing Sn_TX_WRSR upper half (always zero)
//   WR_WRSR_L | writing Sn_TX_WRSR lower half (byte count)
//   WR_CMD    | writing SEND to Sn_CR
//   WAIT_CR   | re-reading Sn_CR until it clears
//   DONE      | success, done pulse follows
//   ERR       | timeout, error pulse follows
//   HOLD      | parked until enable drops
// -----------------------------------------------------------------------------
module w5300_socket_n_tx #(
  parameter int N                   = 0,
  parameter int ETH_TX_BUFFER_WIDTH = 16,
  parameter int FSR_TIMEOUT         = 6000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable_i,
  input  logic [15:0]                    tx_len_i,
  output logic [10:0]                    addr_o,
  output logic [15:0]                    wr_data_o,
  input  logic [15:0]                    rd_data_i,
  input  logic                           op_state_i,
  output logic [ETH_TX_BUFFER_WIDTH-1:0] buf_addr_o,
  input  logic [15:0]                    buf_data_i,
  output logic                           done_o,
  output logic                           error_o
);

  localparam logic [9:0] SOCK_BASE = 10'(32'h200 + 32'h040 * N);
  localparam logic [9:0] REG_CR    = SOCK_BASE + 10'h002;
  localparam logic [9:0] REG_WRSR0 = SOCK_BASE + 10'h020;
  localparam logic [9:0] REG_WRSR1 = SOCK_BASE + 10'h022;
  localparam logic [9:0] REG_FSR0  = SOCK_BASE + 10'h024;
  localparam logic [9:0] REG_FSR1  = SOCK_BASE + 10'h026;
  localparam logic [9:0] REG_FIFOR = SOCK_BASE + 10'h02E;

  localparam int            TW   = $clog2(FSR_TIMEOUT + 1) + 1;
  localparam logic [TW-1:0] TMAX = TW'(FSR_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, RD_FSR_H, RD_FSR_L, CHECK, FETCH, WR_FIFO,
    WR_WRSR_H, WR_WRSR_L, WR_CMD, WAIT_CR, DONE, ERR, HOLD
  } state_t;

  state_t                         state_q, state_d;
  logic                           enable_q;
  logic [15:0]                    tx_len_q, tx_len_d;
  logic [31:0]                    fsr_q, fsr_d;
  logic [TW-1:0]                  timer_q, timer_d;
  logic [15:0]                    word_cnt_q, word_cnt_d;
  logic [ETH_TX_BUFFER_WIDTH-1:0] buf_addr_q, buf_addr_d;
  logic [15:0]                    fifo_word_q, fifo_word_d;
  logic                           done_q, done_d;
  logic                           error_q, error_d;

  logic        en_rise;
  logic        fsr_ok;
  logic [16:0] words;
  logic        last_word;

  assign en_rise   = enable_i & ~enable_q;
  assign fsr_ok    = fsr_q >= {16'h0000, tx_len_q};
  assign words     = ({1'b0, tx_len_q} + 17'd1) >> 1;
  assign last_word = ({1'b0, word_cnt_q} + 17'd1) == words;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (state_q != IDLE && !enable_i) begin
      // Dropping enable abandons the transfer wherever it is.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (en_rise) state_d = (tx_len_i == 16'h0000) ? DONE : RD_FSR_H;
        RD_FSR_H:  if (op_state_i) state_d = RD_FSR_L;
        RD_FSR_L:  if (op_state_i) state_d = CHECK;
        CHECK: begin
          if (fsr_ok)              state_d = FETCH;
          else if (timer_q < TMAX) state_d = RD_FSR_H;
          else                     state_d = ERR;
        end
        FETCH:     state_d = WR_FIFO;
        WR_FIFO:   if (op_state_i) state_d = last_word ? WR_WRSR_H : FETCH;
        WR_WRSR_H: if (op_state_i) state_d = WR_WRSR_L;
        WR_WRSR_L: if (op_state_i) state_d = WR_CMD;
        WR_CMD:    if (op_state_i) state_d = WAIT_CR;
        WAIT_CR:   if (op_state_i && rd_data_i[7:0] == 8'h00) state_d = DONE;
        DONE:      state_d = HOLD;
        ERR:       state_d = HOLD;
        HOLD:      state_d = HOLD;
        default:   state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: bus address/data follow the state directly so the
  // interface never sees a stale address after op_state_i.
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_o    = 11'h000;
    wr_data_o = 16'h0000;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      RD_FSR_H:  addr_o = {1'b0, REG_FSR0};
      RD_FSR_L:  addr_o = {1'b0, REG_FSR1};
      WR_FIFO: begin
        addr_o    = {1'b1, REG_FIFOR};
        wr_data_o = fifo_word_q;
      end
      WR_WRSR_H: addr_o = {1'b1, REG_WRSR0};
      WR_WRSR_L: begin
        addr_o    = {1'b1, REG_WRSR1};
        wr_data_o = tx_len_q;
      end
      WR_CMD: begin
        addr_o    = {1'b1, REG_CR};
        wr_data_o = 16'h0020;
      end
      WAIT_CR:   addr_o = {1'b0, REG_CR};
      DONE:      done_d  = 1'b1;
      ERR:       error_d = 1'b1;
      default:   ;
    endcase
  end

  assign done_o  = done_q;
  assign error_o = error_q;

  // The buffer is a synchronous RAM; presenting the next address lets the
  // word land on buf_data_i in time for the single FETCH cycle.
  assign buf_addr_o = buf_addr_d;

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_len_d    = tx_len_q;
    fsr_d       = fsr_q;
    timer_d     = timer_q;
    word_cnt_d  = word_cnt_q;
    buf_addr_d  = buf_addr_q;
    fifo_word_d = fifo_word_q;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (en_rise) tx_len_d = tx_len_i;
      end
      RD_FSR_H, RD_FSR_L, CHECK: begin
        // Saturates so a long poll cannot wrap back below the limit.
        if (timer_q != TMAX) timer_d = timer_q + TW'(1);
        if (state_q == RD_FSR_H && op_state_i) fsr_d = {rd_data_i, fsr_q[15:0]};
        if (state_q == RD_FSR_L && op_state_i) fsr_d = {fsr_q[31:16], rd_data_i};
        if (state_q == CHECK && fsr_ok) begin
          word_cnt_d = 16'h0000;
          buf_addr_d = '0;
        end
      end
      FETCH:   fifo_word_d = buf_data_i;
      WR_FIFO: begin
        if (op_state_i) begin
          word_cnt_d = word_cnt_q + 16'd1;
          buf_addr_d = buf_addr_q + ETH_TX_BUFFER_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q    <= 1'b0;
      tx_len_q    <= 16'h0000;
      fsr_q       <= 32'h0000_0000;
      timer_q     <= '0;
      word_cnt_q  <= 16'h0000;
      buf_addr_q  <= '0;
      fifo_word_q <= 16'h0000;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      enable_q    <= enable_i;
      tx_len_q    <= tx_len_d;
      fsr_q       <= fsr_d;
      timer_q     <= timer_d;
      word_cnt_q  <= word_cnt_d;
      buf_addr_q  <= buf_addr_d;
      fifo_word_q <= fifo_word_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

endmodule
